// File: rtl/gc_pkg.sv
// Shared opcodes, FSM states and reply kinds
// for the Gamecube console-request responder.
package gc_pkg;

  localparam logic [7:0] GC_CMD_ID     = 8'h00;
  localparam logic [7:0] GC_CMD_RESET  = 8'hFF;
  localparam logic [7:0] GC_CMD_POLL   = 8'h40;
  localparam logic [7:0] GC_CMD_ORIGIN = 8'h41;
  localparam logic [7:0] GC_CMD_CAL    = 8'h42;

  localparam int GC_LEN_W = 5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD0,
    S_POLL1,
    S_POLL2,
    S_CAL1,
    S_CAL2,
    S_WAIT_STOP,
    S_TX,
    S_TX_STOP
  } gc_state_e;

  typedef enum logic [1:0] {
    K_ID,
    K_POLL,
    K_ORIGIN,
    K_CAL
  } gc_kind_e;

endpackage

// File: rtl/gc_reply_shifter.sv
// Reply byte shifter: emits MSB byte first,
// zeros shift in behind the data to form the pad.
module gc_reply_shifter
  import gc_pkg::*;
#(
  parameter int NB = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [NB*8-1:0]     load_data,
  input  logic [GC_LEN_W-1:0] load_len,
  input  logic                next,
  output logic [7:0]          byte_o,
  output logic                last_o
);

  logic [NB*8-1:0]     sr_q, sr_d;
  logic [GC_LEN_W-1:0] cnt_q, cnt_d;
  logic [GC_LEN_W-1:0] len_q, len_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    len_d = len_q;
    if (load) begin
      sr_d  = load_data;
      cnt_d = '0;
      len_d = load_len;
    end else if (next) begin
      sr_d  = sr_q << 8;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  assign byte_o = sr_q[NB*8-1 -: 8];
  assign last_o = (cnt_q == len_q - 1'b1);

endmodule

// File: rtl/gc_responder.sv
// Gamecube controller responder: decodes console
// requests and streams replies to the tx core.
module gc_responder
  import gc_pkg::*;
#(
  parameter logic [23:0] CONTROLLER_ID = 24'h090000,
  parameter int STATE_BYTES = 8,
  parameter int ORIGIN_PAD  = 2,
  parameter logic [STATE_BYTES*8-1:0] ORIGIN_RESET = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_start,
  input  logic                     rx_stop,
  input  logic                     rx_error,
  input  logic                     rx_strobe,
  input  logic [7:0]               rx_data,
  input  logic                     tx_busy,
  output logic                     tx_strobe,
  output logic                     tx_stopbit,
  output logic [7:0]               tx_data,
  input  logic [STATE_BYTES*8-1:0] controller_state,
  output logic                     rumble,
  output logic                     brake,
  output logic [2:0]               poll_mode,
  output logic [7:0]               cmd_count
);

  localparam int NB = (STATE_BYTES > 3) ? STATE_BYTES : 3;
  localparam int SW = STATE_BYTES * 8;
  localparam logic [GC_LEN_W-1:0] LEN_ID = GC_LEN_W'(3);
  localparam logic [GC_LEN_W-1:0] LEN_ST = GC_LEN_W'(STATE_BYTES);
  localparam logic [GC_LEN_W-1:0] LEN_OR =
    GC_LEN_W'(STATE_BYTES + ORIGIN_PAD);

  gc_state_e state_q, state_d;
  gc_kind_e  kind_q, kind_d;
  logic [2:0]    mode_q, mode_d;
  logic [1:0]    flags_q, flags_d;
  logic          rumble_q, rumble_d;
  logic          brake_q, brake_d;
  logic [2:0]    pmode_q, pmode_d;
  logic [7:0]    count_q, count_d;
  logic [SW-1:0] origin_q, origin_d;
  logic          strobe_q, strobe_d;
  logic          stopbit_q, stopbit_d;
  logic [7:0]    data_q, data_d;

  logic                sh_load, sh_next, sh_last;
  logic [NB*8-1:0]     sh_vec;
  logic [GC_LEN_W-1:0] sh_len;
  logic [7:0]          sh_byte;
  logic                abort, tx_go;

  gc_reply_shifter #(.NB(NB)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (sh_load),
    .load_data (sh_vec),
    .load_len  (sh_len),
    .next      (sh_next),
    .byte_o    (sh_byte),
    .last_o    (sh_last)
  );

  assign abort = rx_error | rx_start | rx_stop;
  assign tx_go = !tx_busy && !strobe_q;

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    mode_d    = mode_q;
    flags_d   = flags_q;
    rumble_d  = rumble_q;
    brake_d   = brake_q;
    pmode_d   = pmode_q;
    count_d   = count_q;
    origin_d  = origin_q;
    strobe_d  = 1'b0;
    stopbit_d = 1'b0;
    data_d    = '0;
    sh_load   = 1'b0;
    sh_next   = 1'b0;
    sh_vec    = '0;
    sh_len    = LEN_ID;
    unique case (state_q)
      S_IDLE: begin
        if (rx_start && !rx_error) state_d = S_CMD0;
      end
      S_CMD0: begin
        if (abort) state_d = S_IDLE;
        else if (rx_strobe) begin
          unique case (1'b1)
            (rx_data == GC_CMD_ID),
            (rx_data == GC_CMD_RESET): begin
              kind_d  = K_ID;
              state_d = S_WAIT_STOP;
            end
            (rx_data == GC_CMD_POLL): state_d = S_POLL1;
            (rx_data == GC_CMD_ORIGIN): begin
              kind_d  = K_ORIGIN;
              state_d = S_WAIT_STOP;
            end
            (rx_data == GC_CMD_CAL): state_d = S_CAL1;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_POLL1: begin
        if (abort) state_d = S_IDLE;
        else if (rx_strobe) begin
          mode_d  = rx_data[2:0];
          state_d = S_POLL2;
        end
      end
      S_POLL2: begin
        if (abort) state_d = S_IDLE;
        else if (rx_strobe) begin
          flags_d = rx_data[1:0];
          kind_d  = K_POLL;
          state_d = S_WAIT_STOP;
        end
      end
      S_CAL1: begin
        if (abort) state_d = S_IDLE;
        else if (rx_strobe) state_d = S_CAL2;
      end
      S_CAL2: begin
        if (abort) state_d = S_IDLE;
        else if (rx_strobe) begin
          kind_d  = K_CAL;
          state_d = S_WAIT_STOP;
        end
      end
      S_WAIT_STOP: begin
        if (rx_error || rx_start || rx_strobe) begin
          state_d = S_IDLE;
        end else if (rx_stop) begin
          state_d = S_TX;
          sh_load = 1'b1;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
          unique case (kind_q)
            K_POLL: begin
              rumble_d = flags_q[0];
              brake_d  = flags_q[1];
              pmode_d  = mode_q;
              sh_vec[NB*8-1 -: SW] = controller_state;
              sh_len   = LEN_ST;
            end
            K_CAL: begin
              origin_d = controller_state;
              sh_vec[NB*8-1 -: SW] = controller_state;
              sh_len   = LEN_OR;
            end
            K_ORIGIN: begin
              sh_vec[NB*8-1 -: SW] = origin_q;
              sh_len   = LEN_OR;
            end
            default: begin
              sh_vec[NB*8-1 -: 24] = CONTROLLER_ID;
              sh_len   = LEN_ID;
            end
          endcase
        end
      end
      S_TX: begin
        if (tx_go) begin
          strobe_d = 1'b1;
          data_d   = sh_byte;
          sh_next  = 1'b1;
          if (sh_last) state_d = S_TX_STOP;
        end
      end
      S_TX_STOP: begin
        if (tx_go) begin
          strobe_d  = 1'b1;
          stopbit_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      kind_q    <= K_ID;
      mode_q    <= '0;
      flags_q   <= '0;
      rumble_q  <= 1'b0;
      brake_q   <= 1'b0;
      pmode_q   <= '0;
      count_q   <= '0;
      origin_q  <= ORIGIN_RESET;
      strobe_q  <= 1'b0;
      stopbit_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      mode_q    <= mode_d;
      flags_q   <= flags_d;
      rumble_q  <= rumble_d;
      brake_q   <= brake_d;
      pmode_q   <= pmode_d;
      count_q   <= count_d;
      origin_q  <= origin_d;
      strobe_q  <= strobe_d;
      stopbit_q <= stopbit_d;
      data_q    <= data_d;
    end
  end

  assign tx_strobe  = strobe_q;
  assign tx_stopbit = stopbit_q;
  assign tx_data    = data_q;
  assign rumble     = rumble_q;
  assign brake      = brake_q;
  assign poll_mode  = pmode_q;
  assign cmd_count  = count_q;

endmodule

// File: tb/tb_gc_responder.sv
// Bench for gc_responder: directed and random
// requests checked against a request-level model.
module tb_gc_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_start, rx_stop, rx_error, rx_strobe;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_strobe, tx_stopbit;
  logic [7:0]  tx_data;
  logic [63:0] cstate;
  logic        rumble, brake;
  logic [2:0]  poll_mode;
  logic [7:0]  cmd_count;

  always #5 clk = ~clk;

  gc_responder dut (
    .clk              (clk),
    .reset            (reset),
    .rx_start         (rx_start),
    .rx_stop          (rx_stop),
    .rx_error         (rx_error),
    .rx_strobe        (rx_strobe),
    .rx_data          (rx_data),
    .tx_busy          (tx_busy),
    .tx_strobe        (tx_strobe),
    .tx_stopbit       (tx_stopbit),
    .tx_data          (tx_data),
    .controller_state (cstate),
    .rumble           (rumble),
    .brake            (brake),
    .poll_mode        (poll_mode),
    .cmd_count        (cmd_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] got[$];
  int  viol = 0;
  int  busy_len = 0;
  int  busy_cnt = 0;
  bit  prev_strobe = 0;

  logic [63:0] origin_m = '0;
  int          count_m = 0;
  logic        rumble_m = 0;
  logic        brake_m = 0;
  logic [2:0]  mode_m = '0;

  // tx core stand-in: records strobes, models busy
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_cnt = 0;
        prev_strobe = 0;
      end else begin
        if (tx_strobe) begin
          if (tx_busy || prev_strobe) viol++;
          got.push_back({tx_stopbit, tx_data});
        end
        prev_strobe = tx_strobe;
        if (tx_strobe && busy_len > 0) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
      end
      tx_busy = (busy_cnt > 0);
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: rx_start = 1'b1;
      1: rx_stop  = 1'b1;
      default: rx_error = 1'b1;
    endcase
    @(negedge clk);
    rx_start = 1'b0;
    rx_stop  = 1'b0;
    rx_error = 1'b0;
    idle(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data   = b;
    rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
    idle(1);
  endtask

  task automatic do_req(input logic [7:0] b[$]);
    pulse(0);
    foreach (b[i]) send_byte(b[i]);
    pulse(1);
  endtask

  // Request-level model: reply bytes and side effects
  task automatic model_req(input logic [7:0] b[$],
                           output logic [8:0] r[$]);
    r = {};
    if (b.size() == 1 && (b[0] == 8'h00 || b[0] == 8'hFF)) begin
      r = {9'h009, 9'h000, 9'h000};
    end else if (b.size() == 3 && b[0] == 8'h40) begin
      rumble_m = b[2][0];
      brake_m  = b[2][1];
      mode_m   = b[1][2:0];
      for (int i = 0; i < 8; i++)
        r.push_back({1'b0, 8'((cstate >> (8 * (7 - i))) & 64'hFF)});
    end else if ((b.size() == 1 && b[0] == 8'h41) ||
                 (b.size() == 3 && b[0] == 8'h42)) begin
      if (b[0] == 8'h42) origin_m = cstate;
      for (int i = 0; i < 8; i++)
        r.push_back({1'b0, 8'((origin_m >> (8 * (7 - i))) & 64'hFF)});
      r.push_back(9'h000);
      r.push_back(9'h000);
    end
    if (r.size() > 0) begin
      r.push_back(9'h100);
      if (count_m < 255) count_m++;
    end
  endtask

  task automatic check_reply(input string tag,
                             input logic [8:0] r[$]);
    bit done = 0;
    int limit = (r.size() == 0) ? 30 : 3000;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (r.size() > 0 && got.size() > 0 &&
          got[got.size() - 1][8]) done = 1;
    end
    idle(6);
    if (r.size() > 0) chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_len"}, 64'(got.size()), 64'(r.size()));
    for (int i = 0; i < r.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 64'(got[i]), 64'(r[i]));
    chk({tag, "_cnt"}, 64'(cmd_count), 64'(count_m));
    chk({tag, "_rum"}, 64'(rumble), 64'(rumble_m));
    chk({tag, "_brk"}, 64'(brake), 64'(brake_m));
    chk({tag, "_mode"}, 64'(poll_mode), 64'(mode_m));
    chk({tag, "_hs"}, 64'(viol), 64'd0);
    got.delete();
  endtask

  task automatic run(input string tag,
                     input logic [7:0] b[$],
                     input bit perturb);
    logic [8:0] r[$];
    got.delete();
    model_req(b, r);
    do_req(b);
    if (perturb) cstate = ~cstate;
    check_reply(tag, r);
  endtask

  initial begin
    logic [7:0] req[$];
    logic [8:0] none[$];
    logic [7:0] op;
    bit ok;
    none = {};
    rx_start = 0; rx_stop = 0; rx_error = 0;
    rx_strobe = 0; rx_data = '0; cstate = '0;
    idle(3);
    chk("rst_strobe", 64'(tx_strobe), 64'd0);
    chk("rst_stopbit", 64'(tx_stopbit), 64'd0);
    chk("rst_data", 64'(tx_data), 64'd0);
    chk("rst_cnt", 64'(cmd_count), 64'd0);
    chk("rst_rum", 64'(rumble), 64'd0);
    chk("rst_mode", 64'(poll_mode), 64'd0);
    reset = 1'b1;
    idle(2);

    req = {8'h00};
    run("id", req, 0);
    chk("id_cnt1", 64'(cmd_count), 64'd1);

    cstate = 64'h0080_8080_8080_0000;
    req = {8'h40, 8'h03, 8'h01};
    run("poll", req, 0);
    chk("poll_rum", 64'(rumble), 64'd1);
    chk("poll_mode3", 64'(poll_mode), 64'd3);

    cstate = 64'h1122334455667788;
    req = {8'h42, 8'h00, 8'h00};
    run("cal", req, 0);
    cstate = 64'hDEADBEEF01234567;
    req = {8'h41};
    run("origin", req, 0);

    req = {8'h40};
    run("ab_poll", req, 0);
    req = {8'h00, 8'h12};
    run("ab_extra", req, 0);
    req = {8'h54};
    run("ab_unk", req, 0);
    got.delete();
    pulse(0); send_byte(8'h40); pulse(2);
    send_byte(8'h00); send_byte(8'h00); pulse(1);
    check_reply("ab_err", none);

    busy_len = 50;
    cstate = {$urandom(), $urandom()};
    req = {8'h40, 8'h01, 8'h02};
    run("busy_poll", req, 1);
    req = {8'h41};
    run("busy_org", req, 0);

    for (int it = 0; it < 16; it++) begin
      busy_len = $urandom_range(0, 4);
      cstate = {$urandom(), $urandom()};
      case ($urandom_range(0, 6))
        0: req = {($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00};
        1: req = {8'h40, 8'($urandom()), 8'($urandom())};
        2: req = {8'h41};
        3: req = {8'h42, 8'($urandom()), 8'($urandom())};
        4: begin
          do op = 8'($urandom());
          while (op == 8'h00 || op == 8'hFF ||
                 op == 8'h40 || op == 8'h41 || op == 8'h42);
          req = {op};
        end
        5: req = {8'h42, 8'($urandom())};
        default: req = {8'h41, 8'($urandom())};
      endcase
      run($sformatf("rnd%0d", it), req, $urandom_range(0, 1) != 0);
    end

    // reset while a reply is being shifted out
    busy_len = 10;
    cstate = {$urandom(), $urandom()};
    req = {8'h40, 8'h07, 8'h01};
    got.delete();
    do_req(req);
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (got.size() >= 3) ok = 1;
    end
    chk("midtx_seen", 64'(ok), 64'd1);
    chk("midtx_rum", 64'(rumble), 64'd1);
    reset = 1'b0;
    #1;
    chk("midtx_strobe", 64'(tx_strobe), 64'd0);
    idle(3);
    reset = 1'b1;
    idle(40);
    chk("midtx_nomore", 64'(got.size()), 64'd3);
    chk("midtx_rum0", 64'(rumble), 64'd0);
    got.delete();
    origin_m = '0; count_m = 0;
    rumble_m = 0; brake_m = 0; mode_m = '0;

    // reset during the third poll byte
    cstate = 64'hA5A5A5A5A5A5A5A5;
    req = {8'h42, 8'h00, 8'h00};
    run("cal2", req, 0);
    pulse(0); send_byte(8'h40); send_byte(8'h03);
    @(negedge clk);
    rx_data = 8'h01; rx_strobe = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    rx_strobe = 1'b0;
    idle(2);
    reset = 1'b1;
    origin_m = '0; count_m = 0;
    got.delete();
    pulse(1);
    check_reply("rst3", none);

    busy_len = 0;
    req = {8'h41};
    run("org_rst", req, 0);
    req = {8'hFF};
    run("id_after", req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gc_responder.md
Name: gc_responder

Overview:
- Parametrised successor to the single-command Gamecube controller state machine.
- Decodes console requests from the n_serial_rx event interface and drives the n_serial_tx byte handshake.
- Serves identify (0x00), reset (0xFF), poll (0x40 mm rr), read-origin (0x41) and calibrate (0x42 xx xx) requests. Response length is parametrised, and the block holds its own origin register.
- Sits inside gc_i2c, between the rx/tx cores and the I2C-written controller state.

Parameters:
- CONTROLLER_ID, 24'h090000, 3-byte reply to 0x00/0xFF.
- STATE_BYTES, 8, bytes in poll reply and origin register (1..16).
- ORIGIN_PAD, 2, zero bytes appended after origin bytes in 0x41/0x42 replies (0..7).
- ORIGIN_RESET, {STATE_BYTES*8{1'b0}}, origin register reset value.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- rx_start  in  1  one-cycle pulse, request start detected
- rx_stop  in  1  one-cycle pulse, request stop bit detected
- rx_error  in  1  one-cycle pulse, malformed bit
- rx_strobe  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received byte
- tx_busy  in  1  tx core shifting
- tx_strobe  out  1  one-cycle pulse, load tx_data/tx_stopbit
- tx_stopbit  out  1  with strobe: send stop bit instead of byte
- tx_data  out  8  byte to send
- controller_state  in  STATE_BYTES*8  live state, MSB byte sent first
- rumble  out  1  poll byte 2 bit 0, latched at stop
- brake  out  1  poll byte 2 bit 1, latched at stop
- poll_mode  out  3  poll byte 1 bits [2:0], latched at stop
- cmd_count  out  8  saturating count of requests answered

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; origin <= ORIGIN_RESET; state S_IDLE.
  - Reset mid-transmission abandons the reply immediately and emits no further strobe.
- States:
  - S_IDLE
  - S_CMD0, S_POLL1, S_POLL2, S_CAL1, S_CAL2
  - S_WAIT_STOP (latched kind: ID, POLL, ORIGIN, CAL)
  - S_TX, S_TX_STOP
- Receive path:
  - S_IDLE: rx_start -> S_CMD0. Other rx events ignored.
  - S_CMD0 byte decode:
    - 0x00 or 0xFF -> WAIT_STOP(ID).
    - 0x40 -> S_POLL1.
    - 0x41 -> WAIT_STOP(ORIGIN).
    - 0x42 -> S_CAL1.
    - Any other byte -> S_IDLE.
  - S_POLL1: any byte is accepted; mode <= byte[2:0]; -> S_POLL2.
  - S_POLL2: any byte is accepted; flags <= byte[1:0]; -> WAIT_STOP(POLL).
  - S_CAL1 -> S_CAL2 -> WAIT_STOP(CAL). Byte contents are ignored.
  - Abort rule: in any receive state, rx_start, rx_error, or rx_stop arriving before the command is complete -> S_IDLE with no reply.
  - Abort rule: in WAIT_STOP, an extra rx_strobe -> S_IDLE with no reply.
  - Precedence: if rx_error and any other event coincide, the error wins.
- On rx_stop in WAIT_STOP:
  - Set up the reply and enter S_TX.
  - Increment cmd_count, saturating at 255.
  - POLL: rumble/brake <= flags; poll_mode <= mode; shift register <= controller_state; length = STATE_BYTES.
  - CAL: origin <= controller_state in the same cycle. The reply carries the new value.
  - ORIGIN/CAL: length = STATE_BYTES + ORIGIN_PAD. Origin bytes are sent MSB first, then the zero pad bytes.
  - ID: length = 3; bytes are CONTROLLER_ID[23:16], [15:8], [7:0].
- Transmit handshake:
  - In S_TX or S_TX_STOP with tx_busy=0 and tx_strobe not asserted in the previous cycle: pulse tx_strobe for one cycle with tx_data valid.
  - At least one idle cycle separates strobes. This lets tx_busy rise.
  - The byte counter runs 0..length-1 (width covers 23), then -> S_TX_STOP.
  - S_TX_STOP emits one strobe with tx_stopbit=1 and tx_data=0, then -> S_IDLE.
  - tx_stopbit=0 on byte strobes.
- Latency: the first reply strobe comes no earlier than 1 cycle after rx_stop, gated only by tx_busy.
- controller_state changing during transmission does not alter the reply; it is latched at stop.
- rx events during S_TX/S_TX_STOP are ignored; no queuing.

Decomposition:
- Shared package gc_pkg:
  - Opcode constants GC_CMD_ID=8'h00, GC_CMD_RESET=8'hFF, GC_CMD_POLL=8'h40, GC_CMD_ORIGIN=8'h41, GC_CMD_CAL=8'h42.
  - State encoding and reply-kind encoding.
- One sub-module, gc_reply_shifter:
  - Loads a byte vector plus length.
  - Emits bytes on request.
  - Appends zero pad bytes.
  - Flags last byte.

Test Plan:
- ID request: start, 0x00, stop, with tx_busy held 0 -> strobes carry 0x09, 0x00, 0x00, then stopbit; cmd_count=1.
- Poll request: start, 0x40, 0x03, 0x01, stop, with controller_state=64'h0080_8080_8080_0000 -> 8 bytes 00 80 80 80 80 80 00 00, then stopbit; rumble=1, brake=0, poll_mode=3.
- Calibrate then origin: state 64'h1122334455667788; request 0x42 0x00 0x00 -> 10 bytes 11..88 00 00. Then change state and send 0x41 -> the same 10 bytes.
- Aborts:
  - 0x40 then stop -> no tx_strobe, cmd_count unchanged.
  - 0x00 then an extra byte then stop -> no reply.
  - Unknown opcode 0x54 -> no reply.
- tx_busy held 1 for 50 cycles after each strobe -> exactly one strobe per busy-low window. Bytes arrive in order with no duplicates.
- Reset asserted (0) during the third poll byte -> tx_strobe stays 0, rumble=0, origin back to ORIGIN_RESET. After release, a new ID request completes normally.
